// File: rtl/tt7_sweep_capture.sv
// Truth-table capture harness: sweeps every minterm onto x_out, samples f_in and returns
// the table, its ones-count and (with TT_COMPARE_EN defined) a match against EXPECT_TT.
module tt7_sweep_capture #(
  parameter int                         NVARS     = 7,
  parameter int                         SETTLE    = 0,
  parameter logic [(2**NVARS)-1:0]      EXPECT_TT = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic [NVARS-1:0]       x_out,
  input  logic                   f_in,
  output logic                   busy,
  output logic [(2**NVARS)-1:0]  tt,
  output logic [NVARS:0]         pop_count,
  output logic                   tt_valid,
  input  logic                   tt_ready,
  output logic                   match,
  output logic [1:0]             state_o
);

  localparam int TTW = 2**NVARS;
  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Handshake: the result (tt, pop_count, match) is offered while tt_valid is high and
  // stays frozen until an edge where tt_valid & tt_ready; that edge consumes it.
  state_t            state_q, state_d;
  logic [NVARS-1:0]  x_q, x_d;
  logic [TTW-1:0]    tt_q, tt_d;
  logic [NVARS:0]    pop_q, pop_d;
  logic [3:0]        settle_q, settle_d;
  logic              sample;
  logic              last;

  assign sample = (state_q == S_RUN) && (settle_q == SETTLE_L);
  assign last   = (x_q == {NVARS{1'b1}});

`ifdef TT_COMPARE_EN
  logic match_q, match_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      tt_q     <= '0;
      pop_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      tt_q     <= tt_d;
      pop_q    <= pop_d;
      settle_q <= settle_d;
    end
  end

`ifdef TT_COMPARE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    tt_d     = tt_q;
    pop_d    = pop_q;
    settle_d = settle_q;
`ifdef TT_COMPARE_EN
    match_d  = match_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          x_d      = '0;
          tt_d     = '0;
          pop_d    = '0;
          settle_d = '0;
`ifdef TT_COMPARE_EN
          match_d  = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d  = S_IDLE;
          x_d      = '0;
          tt_d     = '0;
          pop_d    = '0;
          settle_d = '0;
`ifdef TT_COMPARE_EN
          match_d  = 1'b0;
`endif
        end else if (sample) begin
          tt_d[x_q] = f_in;
          pop_d     = pop_q + (NVARS+1)'(f_in);
          settle_d  = '0;
          x_d       = x_q + NVARS'(1);
          if (last) begin
            state_d = S_HOLD;
`ifdef TT_COMPARE_EN
            match_d = (tt_d == EXPECT_TT);
`endif
          end
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      S_HOLD: begin
        // start is deliberately not looked at here: requests are never queued.
        if (abort) begin
          state_d  = S_IDLE;
          x_d      = '0;
          tt_d     = '0;
          pop_d    = '0;
          settle_d = '0;
`ifdef TT_COMPARE_EN
          match_d  = 1'b0;
`endif
        end else if (tt_ready) begin
          state_d  = S_IDLE;
`ifdef TT_COMPARE_EN
          match_d  = 1'b0;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign x_out     = x_q;
  assign tt        = tt_q;
  assign pop_count = pop_q;
  assign busy      = (state_q == S_RUN);
  assign tt_valid  = (state_q == S_HOLD);
  assign state_o   = state_q;

`ifdef TT_COMPARE_EN
  assign match = match_q;
`else
  // Folds to constant 0; the reference keeps EXPECT_TT used in this build.
  assign match = 1'b0 & (|EXPECT_TT);
`endif

endmodule

// File: tb/tb_tt7_sweep_capture.sv
// Bench for tt7_sweep_capture: one instance with SETTLE=0 (d=0) and one with SETTLE=3 (d=1).
module tb_tt7_sweep_capture;

  localparam logic [127:0] T1   = 128'hfeeafee8fee8a880feeae880e880a880;
  localparam logic [127:0] T1F  = 128'hfeeafee8fee8a880feeae880e880a800;
  localparam logic [127:0] TALT = {32{4'ha}};

  logic         clk;
  logic         rst;
  logic         start [2];
  logic         abort [2];
  logic [6:0]   x_out [2];
  logic         f_in [2];
  logic         busy [2];
  logic [127:0] tt [2];
  logic [7:0]   pop_count [2];
  logic         tt_valid [2];
  logic         tt_ready [2];
  logic         match [2];
  logic [1:0]   state_o [2];

  logic [127:0] tbl [2];
  logic [1:0]   phase;
  logic         rnd_bit;
  logic         glitch_on;

  int total;
  int bad;

  tt7_sweep_capture #(.NVARS(7), .SETTLE(0), .EXPECT_TT(T1)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .x_out(x_out[0]),
    .f_in(f_in[0]), .busy(busy[0]), .tt(tt[0]), .pop_count(pop_count[0]),
    .tt_valid(tt_valid[0]), .tt_ready(tt_ready[0]), .match(match[0]), .state_o(state_o[0])
  );

  tt7_sweep_capture #(.NVARS(7), .SETTLE(3), .EXPECT_TT(TALT)) dut3 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .x_out(x_out[1]),
    .f_in(f_in[1]), .busy(busy[1]), .tt(tt[1]), .pop_count(pop_count[1]),
    .tt_valid(tt_valid[1]), .tt_ready(tt_ready[1]), .match(match[1]), .state_o(state_o[1])
  );

  // The "function under test" is a lookup table; the SETTLE=3 side gets noise except in
  // the cycle that precedes each sample edge (every 4th edge after start).
  assign f_in[0] = tbl[0][x_out[0]];
  assign f_in[1] = tbl[1][x_out[1]] ^ (glitch_on & (phase != 2'd3) & rnd_bit);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) phase <= start[1] ? 2'd0 : phase + 2'd1;
  always @(negedge clk) rnd_bit <= 1'($urandom);

  typedef struct {
    int           d;
    logic [127:0] tbl;
    logic [127:0] exp_tt;
    int           exp_pop;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int d, input logic [127:0] t, input logic [127:0] e, input int p);
    vec_t v;
    v.d = d; v.tbl = t; v.exp_tt = e; v.exp_pop = p;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic exp_match(input int d, input logic [127:0] t);
    logic m;
    m = (t == ((d == 0) ? T1 : TALT));
`ifdef TT_COMPARE_EN
    return m;
`else
    return 1'b0 & m;
`endif
  endfunction

  task automatic pulse_start(input int d);
    @(negedge clk); start[d] = 1'b1;
    @(posedge clk); #1 start[d] = 1'b0;
  endtask

  // Starts a sweep and follows it edge by edge until the result is offered.
  task automatic run_sweep(input int d, input logic [127:0] exp_tt, input int exp_pop);
    int s, lat, n, bad_x;
    s = (d == 0) ? 1 : 4;
    lat = 128 * s;
    n = 0;
    bad_x = 0;
    pulse_start(d);
    while (!tt_valid[d] && n < 2 * lat) begin
      if (x_out[d] !== 7'((n / s) % 128) || busy[d] !== 1'b1) bad_x++;
      @(posedge clk); #1 n++;
    end
    chk($sformatf("latency d%0d", d), 128'(n), 128'(lat));
    chk($sformatf("x_seq d%0d", d), 128'(bad_x), 128'd0);
    chk($sformatf("tt d%0d", d), tt[d], exp_tt);
    chk($sformatf("pop d%0d", d), 128'(pop_count[d]), 128'(exp_pop));
    chk($sformatf("match d%0d", d), 128'(match[d]), 128'(exp_match(d, exp_tt)));
    chk($sformatf("x_wrap d%0d", d), 128'(x_out[d]), 128'd0);
    chk($sformatf("busy_end d%0d", d), 128'(busy[d]), 128'd0);
  endtask

  task automatic handshake(input int d, input logic [127:0] exp_tt);
    @(negedge clk); tt_ready[d] = 1'b1;
    @(posedge clk); #1 tt_ready[d] = 1'b0;
    chk("hs_valid", 128'(tt_valid[d]), 128'd0);
    chk("hs_state", 128'(state_o[d]), 128'd0);
    chk("hs_tt_kept", tt[d], exp_tt);
    chk("hs_match", 128'(match[d]), 128'd0);
  endtask

  initial begin
    logic [127:0] r;
    int n;
    total = 0;
    bad = 0;
    glitch_on = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; abort[d] = 1'b0; tt_ready[d] = 1'b0; tbl[d] = '0;
    end

    add_vec(0, T1, T1, 64);
    add_vec(0, '0, '0, 0);
    add_vec(0, '1, '1, 128);
    add_vec(1, TALT, TALT, 64);
    add_vec(0, T1F, T1F, 63);
    for (int i = 0; i < 4; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      add_vec(i % 2, r, r, $countones(r));
    end

    rst = 1'b1;
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_x", 128'(x_out[d]), 128'd0);
      chk("rst_busy", 128'(busy[d]), 128'd0);
      chk("rst_tt", tt[d], 128'd0);
      chk("rst_pop", 128'(pop_count[d]), 128'd0);
      chk("rst_valid", 128'(tt_valid[d]), 128'd0);
      chk("rst_match", 128'(match[d]), 128'd0);
    end
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      tbl[vecs[i].d] = vecs[i].tbl;
      run_sweep(vecs[i].d, vecs[i].exp_tt, vecs[i].exp_pop);
      handshake(vecs[i].d, vecs[i].exp_tt);
    end

    // Stall in HOLD with start pulses, then start coinciding with the handshake.
    tbl[0] = T1;
    run_sweep(0, T1, 64);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); start[0] = (c % 3 == 0);
    end
    @(negedge clk); start[0] = 1'b0;
    #1;
    chk("stall_valid", 128'(tt_valid[0]), 128'd1);
    chk("stall_tt", tt[0], T1);
    chk("stall_busy", 128'(busy[0]), 128'd0);
    chk("stall_x", 128'(x_out[0]), 128'd0);
    @(negedge clk); tt_ready[0] = 1'b1; start[0] = 1'b1;
    @(posedge clk); #1 tt_ready[0] = 1'b0; start[0] = 1'b0;
    chk("hs_start_busy", 128'(busy[0]), 128'd0);
    chk("hs_start_valid", 128'(tt_valid[0]), 128'd0);
    @(posedge clk); #1;
    chk("hs_start_idle", 128'(state_o[0]), 128'd0);

    // abort in IDLE leaves the retained table alone
    @(negedge clk); abort[0] = 1'b1;
    @(posedge clk); #1 abort[0] = 1'b0;
    chk("abort_idle_tt", tt[0], T1);

    // abort at minterm 50
    tbl[0] = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
    pulse_start(0);
    n = 0;
    while (x_out[0] != 7'd50 && n < 300) begin
      @(posedge clk); #1 n++;
    end
    chk("reach_50", 128'(n), 128'd50);
    @(negedge clk); abort[0] = 1'b1;
    @(posedge clk); #1 abort[0] = 1'b0;
    chk("abort_busy", 128'(busy[0]), 128'd0);
    chk("abort_tt", tt[0], 128'd0);
    chk("abort_x", 128'(x_out[0]), 128'd0);
    chk("abort_pop", 128'(pop_count[0]), 128'd0);
    repeat (3) @(posedge clk);
    #1 chk("abort_stays_idle", 128'(busy[0]), 128'd0);

    // abort in HOLD drops the result
    tbl[0] = '1;
    run_sweep(0, '1, 128);
    @(negedge clk); abort[0] = 1'b1;
    @(posedge clk); #1 abort[0] = 1'b0;
    chk("abort_hold_valid", 128'(tt_valid[0]), 128'd0);
    chk("abort_hold_tt", tt[0], 128'd0);
    chk("abort_hold_pop", 128'(pop_count[0]), 128'd0);

    // reset mid-sweep on both instances
    tbl[0] = '1; tbl[1] = '1;
    @(negedge clk); start[0] = 1'b1; start[1] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0; start[1] = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("mrst_x", 128'(x_out[d]), 128'd0);
      chk("mrst_busy", 128'(busy[d]), 128'd0);
      chk("mrst_tt", tt[d], 128'd0);
      chk("mrst_pop", 128'(pop_count[d]), 128'd0);
      chk("mrst_valid", 128'(tt_valid[d]), 128'd0);
    end
    @(negedge clk); rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mrst_no_resume0", 128'(busy[0]), 128'd0);
    chk("mrst_no_resume1", 128'(busy[1]), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
